// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO read-side drain engine.
// Skid depth sets the read credit; pointer and occupancy widths follow from it.
package fifo_pkg;
   localparam int DATA_W_DEF = 8;
   localparam int SKID_DEPTH = 3;
   localparam int OCC_W      = $clog2(SKID_DEPTH + 1);
   localparam int PTR_W      = $clog2(SKID_DEPTH);
   localparam int BEAT_W     = 8;

   // Circular pointer step for a non-power-of-two depth.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction
endpackage

// File: rtl/rd_skid_buffer.sv
// Small circular buffer that absorbs bytes already in flight from the FIFO.
// Head data reads as zero while empty so the stream never shows stale bytes.
module rd_skid_buffer
   import fifo_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] head_data,
   output logic [OCC_W-1:0]  occ
);
   logic [SKID_DEPTH-1:0][DATA_W-1:0] mem;
   logic [PTR_W-1:0]                  head;
   logic [PTR_W-1:0]                  tail;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem  <= '0;
         head <= '0;
         tail <= '0;
         occ  <= '0;
      end else begin
         if (push) begin
            mem[tail] <= push_data;
            tail      <= ptr_inc(tail);
         end
         if (pop)
            head <= ptr_inc(head);
         case ({push, pop})
            2'b10:   occ <= occ + OCC_W'(1);
            2'b01:   occ <= occ - OCC_W'(1);
            default: occ <= occ;
         endcase
      end
   end

   assign head_data = (occ != '0) ? mem[head] : '0;

   a_no_overflow: assert property (@(posedge clk) disable iff (reset)
      !(push && !pop && occ == OCC_W'(SKID_DEPTH)));
   a_no_underflow: assert property (@(posedge clk) disable iff (reset)
      !(pop && occ == '0));
endmodule

// File: rtl/fifo_rd_stream.sv
// Drains the synchronous FIFO read port into a framed valid/ready stream.
// Reads are credit-limited by skid space, so m_ready never reaches fifo_rd_en.
module fifo_rd_stream
   import fifo_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int PKT_LEN = 4,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_data_out,
   output logic              fifo_rd_en,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_last,
   output logic [CNT_W-1:0]  rd_count
);
   logic              pend;
   logic              pop;
   logic [OCC_W-1:0]  occ;
   logic [OCC_W:0]    credit_used;
   logic [BEAT_W-1:0] beat;

   // Bytes buffered plus the one in flight must fit in the skid buffer.
   assign credit_used = {1'b0, occ} + {{OCC_W{1'b0}}, pend};
   assign fifo_rd_en  = ~reset & enable & ~fifo_empty &
                        (credit_used < (OCC_W+1)'(SKID_DEPTH));

   assign m_valid = (occ != '0);
   assign pop     = m_valid & m_ready;
   assign m_last  = m_valid & (beat == BEAT_W'(PKT_LEN - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend     <= 1'b0;
         beat     <= '0;
         rd_count <= '0;
      end else begin
         pend <= fifo_rd_en;
         if (fifo_rd_en)
            rd_count <= rd_count + CNT_W'(1);
         if (pop)
            beat <= (beat == BEAT_W'(PKT_LEN - 1)) ? '0 : beat + BEAT_W'(1);
      end
   end

   rd_skid_buffer #(.DATA_W(DATA_W)) u_skid (
      .clk       (clk),
      .reset     (reset),
      .push      (pend),
      .push_data (fifo_data_out),
      .pop       (pop),
      .head_data (m_data),
      .occ       (occ)
   );

   a_credit: assert property (@(posedge clk) disable iff (reset)
      credit_used <= (OCC_W+1)'(SKID_DEPTH));
endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
Drain engine for the read port of the team's 8-bit synchronous FIFO. It drives the FIFO's read enable and absorbs the FIFO's one-cycle registered read latency. Data is presented downstream on a valid/ready stream with packet framing (last flag every PKT_LEN bytes). A 3-entry internal skid buffer gives full one-byte-per-cycle throughput without any combinational path from m_ready to fifo_rd_en.

Parameters:
DATA_W, 8, data width; must match the FIFO data width.
PKT_LEN, 4, bytes per packet; m_last marks beat PKT_LEN; legal range 1..255.
CNT_W, 16, width of the rd_count statistics counter.

Ports:
clk  input  1  sole clock, rising edge.
reset  input  1  asynchronous, active-high reset.
enable  input  1  1 = permitted to issue new FIFO reads.
fifo_empty  input  1  FIFO empty flag.
fifo_data_out  input  DATA_W  FIFO read data; valid the cycle after an accepted read.
fifo_rd_en  output  1  FIFO read enable.
m_data  output  DATA_W  downstream data (head of skid buffer).
m_valid  output  1  downstream data valid.
m_ready  input  1  downstream accept.
m_last  output  1  current beat is the final beat of a packet.
rd_count  output  CNT_W  total accepted FIFO reads since reset; wraps modulo 2^CNT_W.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high (reset). While reset is high:
  - occupancy, pend, beat counter and rd_count are 0;
  - buffer pointers are 0;
  - m_valid=0, m_last=0, m_data=0;
  - fifo_rd_en is forced 0.
- Reset mid-operation discards buffered and in-flight bytes. No output glitches to valid.
- Read accepted: a read is accepted at an edge iff fifo_rd_en=1 and fifo_empty=0 at that edge.
- Issue rule: fifo_rd_en = enable & ~fifo_empty & (occ + pend < 3). Here occ is skid-buffer occupancy (0..3) and pend is the in-flight flag.
  - fifo_rd_en is a combinational function of registered state, enable and fifo_empty only.
  - m_ready never feeds fifo_rd_en.
- pend: set at an accepted-read edge, else cleared.
- Capture: when pend=1, fifo_data_out is written into the buffer at the tail on the next edge, and the tail pointer advances.
- Latency: first byte's accepted-read edge E0 → buffered at E1 → m_valid=1 in the cycle after E1. That is 2 cycles from fifo_rd_en to m_valid.
- Pop: m_valid & m_ready at an edge. Head pointer advances, occ decrements.
  - Simultaneous capture and pop: occ is unchanged.
  - Pointers wrap 2→0.
- Stream rules: m_valid = (occ != 0).
  - m_data and m_last are held stable while m_valid=1 and m_ready=0.
  - m_data is unknown-free (0) when empty.
- Framing:
  - The beat counter (0..PKT_LEN-1) increments on each pop and wraps to 0 after the last beat.
  - m_last = m_valid & (beat == PKT_LEN-1).
  - PKT_LEN=1 → m_last on every valid beat.
- rd_count increments on each accepted read, not on each pop.
- Credit invariant: occ + pend ≤ 3 at all times, so overflow is impossible. An assertion covers this.
- enable deasserted mid-stream: no new reads. The in-flight byte is still captured, and all buffered bytes still drain normally.
- m_ready held 0: at most 3 reads are issued, then fifo_rd_en stays 0 until a pop.
- fifo_empty is treated as authoritative. If the FIFO does not accept a read, no pend is raised.

Decomposition:
- Shared package (fifo_pkg): DATA_W default, SKID_DEPTH=3 constant, occupancy/pointer widths derived from SKID_DEPTH.
- One sub-module: rd_skid_buffer (3-entry circular buffer with push/pop/occ/head data). fifo_rd_stream owns the issue logic, pend, framing and rd_count.

Test Plan:
1. Assert reset for 3 cycles with enable=1, fifo_empty=0 → fifo_rd_en=0, m_valid=0, m_last=0, rd_count=0 throughout.
2. FIFO preloaded 0x11,0x22,0x33,0x44; enable=1, m_ready=1 →
   - m_data sequence 0x11,0x22,0x33,0x44 on consecutive cycles;
   - m_valid first rises 2 cycles after first fifo_rd_en;
   - m_last only on 0x44;
   - rd_count=4.
3. FIFO holds 0xA0..0xA3, m_ready=0 →
   - exactly 3 accepted reads, then fifo_rd_en=0;
   - m_data stays 0xA0;
   - after releasing m_ready: 0xA0,0xA1,0xA2,0xA3 in order, no loss or duplication.
4. 8 bytes streamed, m_ready=1 → fifo_rd_en high 8 consecutive cycles and m_valid high 8 consecutive cycles. m_last on beats 4 and 8.
5. enable dropped the cycle after the 2nd accepted read → the 2nd byte is still delivered, no further fifo_rd_en, rd_count=2.
6. Assert reset asynchronously with occ=2, pend=1 → m_valid falls without waiting for clk. After reset: rd_count=0, beat counter 0, next packet's m_last on its 4th beat.
